// File: rtl/pc_branch_unit_pkg.sv
// Shared control-decode definitions: condition codes, flag bit positions
// and the PC sequencer state encoding.
package wisc_pkg;

   // Condition codes carried in branch[2:0]
   localparam logic [2:0] NEQ    = 3'b000;
   localparam logic [2:0] EQ     = 3'b001;
   localparam logic [2:0] GT     = 3'b010;
   localparam logic [2:0] LT     = 3'b011;
   localparam logic [2:0] GTE    = 3'b100;
   localparam logic [2:0] LTE    = 3'b101;
   localparam logic [2:0] OVFL   = 3'b110;
   localparam logic [2:0] UNCOND = 3'b111;

   // Bit positions inside the {Z,V,N} flag vector
   localparam int Z_BIT = 2;
   localparam int V_BIT = 1;
   localparam int N_BIT = 0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      RET_WAIT = 2'd1,
      HALT     = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_branch_unit_cond_eval.sv
// Condition-code evaluator: decides whether a branch with code ccc is taken
// given the effective {Z,V,N} flags. Purely combinational so hazard logic
// can share it.
module cond_eval
   import wisc_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic [2:0] ef,
   output logic       take
);

   logic z, v, n;

   assign z = ef[Z_BIT];
   assign v = ef[V_BIT];
   assign n = ef[N_BIT];

   // Map each condition code onto the flag equation it tests
   always_comb begin
      take = 1'b0;
      case (ccc)
         NEQ:     take = !z;
         EQ:      take = z;
         GT:      take = !z && !n;
         LT:      take = n;
         GTE:     take = z || (!z && !n);
         LTE:     take = n || z;
         OVFL:    take = v;
         UNCOND:  take = 1'b1;
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, flag register and B/CALL/RET/HLT redirect resolution.
// Optional return-address stack enabled by defining PC_BRANCH_RAS_EN; without
// it every RET waits for the return address from stack memory.
module pc_branch_unit
   import wisc_pkg::*;
#(
   parameter int PC_W      = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic [3:0]      branch,
   input  logic            call,
   input  logic            ret,
   input  logic            hlt,
   input  logic [11:0]     imm,
   input  logic [2:0]      alu_flags,
   input  logic            flag_we,
   input  logic [PC_W-1:0] ret_addr,
   input  logic            ret_vld,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_link,
   output logic [2:0]      flags,
   output logic            redirect,
   output logic            busy,
   output logic            halted
);

   pc_state_e       state;
   logic [2:0]      ef;
   logic            take;
   logic [PC_W-1:0] br_tgt;
   logic [PC_W-1:0] call_tgt;

`ifdef PC_BRANCH_RAS_EN
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   // Entry 0 is the top of stack; deeper entries are older
   logic [PC_W-1:0] ras [RAS_DEPTH];
   logic [CNT_W-1:0] ras_cnt;
`endif

   // Forward this cycle's ALU flags so a compare and its branch can issue together
   assign ef      = flag_we ? alu_flags : flags;
   assign pc_link = pc + PC_W'(1);
   assign br_tgt   = pc_link + {{(PC_W-9){imm[8]}}, imm[8:0]};
   assign call_tgt = pc_link + {{(PC_W-12){imm[11]}}, imm[11:0]};

   cond_eval u_cond_eval (
      .ccc  (branch[2:0]),
      .ef   (ef),
      .take (take)
   );

   // Sequencer: PC update, flag writes, redirect pulse and RUN/RET_WAIT/HALT
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         pc       <= '0;
         flags    <= '0;
         redirect <= 1'b0;
         busy     <= 1'b0;
         halted   <= 1'b0;
`ifdef PC_BRANCH_RAS_EN
         ras_cnt  <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
`endif
      end else begin
         redirect <= 1'b0;
         case (state)
            RUN: begin
               if (flag_we) flags <= alu_flags;
               if (!stall) begin
                  if (call) begin
                     pc       <= call_tgt;
                     redirect <= 1'b1;
`ifdef PC_BRANCH_RAS_EN
                     // Push link; a full stack silently drops its oldest entry
                     for (int i = RAS_DEPTH - 1; i > 0; i--) ras[i] <= ras[i-1];
                     ras[0] <= pc_link;
                     if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
`endif
                  end else if (branch[3]) begin
                     if (take) begin
                        pc       <= br_tgt;
                        redirect <= 1'b1;
                     end else begin
                        pc <= pc_link;
                     end
                  end else if (ret) begin
`ifdef PC_BRANCH_RAS_EN
                     if (ras_cnt != '0) begin
                        pc       <= ras[0];
                        redirect <= 1'b1;
                        for (int i = 0; i < RAS_DEPTH - 1; i++) ras[i] <= ras[i+1];
                        ras_cnt  <= ras_cnt - CNT_W'(1);
                     end else begin
                        state <= RET_WAIT;
                        busy  <= 1'b1;
                     end
`else
                     state <= RET_WAIT;
                     busy  <= 1'b1;
`endif
                  end else if (hlt) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     pc <= pc_link;
                  end
               end
            end
            RET_WAIT: begin
               if (flag_we) flags <= alu_flags;
               // Return address is accepted regardless of stall
               if (ret_vld) begin
                  pc       <= ret_addr;
                  redirect <= 1'b1;
                  busy     <= 1'b0;
                  state    <= RUN;
               end
            end
            HALT: begin
               halted <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit.
module tb_pc_branch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic [3:0]  branch;
   logic        call;
   logic        ret;
   logic        hlt;
   logic [11:0] imm;
   logic [2:0]  alu_flags;
   logic        flag_we;
   logic [15:0] ret_addr;
   logic        ret_vld;
   logic [15:0] pc;
   logic [15:0] pc_link;
   logic [2:0]  flags;
   logic        redirect;
   logic        busy;
   logic        halted;

   int errors = 0;
   int checks = 0;

   pc_branch_unit #(.PC_W(16), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch(branch), .call(call),
      .ret(ret), .hlt(hlt), .imm(imm), .alu_flags(alu_flags), .flag_we(flag_we),
      .ret_addr(ret_addr), .ret_vld(ret_vld), .pc(pc), .pc_link(pc_link),
      .flags(flags), .redirect(redirect), .busy(busy), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      stall = 0; branch = 4'b0000; call = 0; ret = 0; hlt = 0; imm = 12'h000;
      alu_flags = 3'b000; flag_we = 0; ret_addr = 16'h0000; ret_vld = 0;
   endtask

   initial begin
      idle_in();
      rst = 1;
      tick(); tick();
      rst = 0;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_flags", flags, 3'b000);
      chk("rst_redirect", redirect, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_halted", halted, 1'b0);

      // three idle cycles
      tick(); chk("idle1_pc", pc, 16'h0001);
      tick(); chk("idle2_pc", pc, 16'h0002);
      tick(); chk("idle3_pc", pc, 16'h0003);
      chk("idle_redirect", redirect, 1'b0);
      chk("idle_flags", flags, 3'b000);

      // UNCOND branch 0x003 -> 0x004+0x00C = 0x0010
      branch = 4'b1111; imm = 12'h00C;
      tick(); idle_in();
      chk("uncond_pc", pc, 16'h0010);
      chk("uncond_redirect", redirect, 1'b1);

      // EQ with forwarded Z=1, offset -2: 0x0011-2 = 0x000F
      branch = 4'b1001; flag_we = 1; alu_flags = 3'b100; imm = 12'h1FE;
      tick(); idle_in();
      chk("eq_taken_pc", pc, 16'h000F);
      chk("eq_taken_redirect", redirect, 1'b1);
      chk("eq_flags", flags, 3'b100);
      tick();
      chk("eq_pulse_end", redirect, 1'b0);
      chk("eq_after_pc", pc, 16'h0010);

      // EQ with forwarded Z=0: falls through
      branch = 4'b1001; flag_we = 1; alu_flags = 3'b000; imm = 12'h1FE;
      tick(); idle_in();
      chk("eq_nt_pc", pc, 16'h0011);
      chk("eq_nt_redirect", redirect, 1'b0);

      // GT using registered flags (000): taken, 0x0012+0x10 = 0x0022
      branch = 4'b1010; imm = 12'h010;
      tick(); idle_in();
      chk("gt_reg_pc", pc, 16'h0022);

      // LT with forwarded N=0 overrides nothing: not taken -> 0x0023
      branch = 4'b1011; flag_we = 1; alu_flags = 3'b000;
      tick(); idle_in();
      chk("lt_nt_pc", pc, 16'h0023);

      // stall holds pc but honours flag_we
      stall = 1; branch = 4'b1111; imm = 12'h050; flag_we = 1; alu_flags = 3'b011;
      tick(); idle_in();
      chk("stall_pc", pc, 16'h0023);
      chk("stall_flags", flags, 3'b011);
      chk("stall_redirect", redirect, 1'b0);

      // UNCOND offset -0x25 (0x1DB): 0x0024-0x25 = 0xFFFF
      branch = 4'b1111; imm = 12'h1DB;
      tick(); idle_in();
      chk("to_ffff_pc", pc, 16'hFFFF);
      tick();
      chk("wrap_pc", pc, 16'h0000);

      // CALL +0xFF -> 0x0100
      call = 1; imm = 12'h0FF;
      tick(); idle_in();
      chk("call1_pc", pc, 16'h0100);
      call = 1; imm = 12'h800;
      chk("call_link", pc_link, 16'h0101);
      tick(); idle_in();
      chk("call_neg_pc", pc, 16'hF901);
      chk("call_neg_redirect", redirect, 1'b1);

      // Reset mid RET_WAIT
      rst = 1; tick(); rst = 0;
      chk("rst2_pc", pc, 16'h0000);

`ifndef PC_BRANCH_RAS_EN
      ret = 1;
      tick(); idle_in();
      chk("retw_busy0", busy, 1'b1);
      rst = 1; tick(); rst = 0;
      chk("rst_retw_busy", busy, 1'b0);
      chk("rst_retw_pc", pc, 16'h0000);

      // CALL +0x1FF -> 0x0200, then RET waits for the address
      call = 1; imm = 12'h1FF;
      tick(); idle_in();
      chk("to_200_pc", pc, 16'h0200);
      ret = 1;
      tick(); idle_in();
      chk("ret_busy", busy, 1'b1);
      chk("ret_pc", pc, 16'h0200);
      for (int k = 0; k < 3; k++) begin
         stall = 1; call = 1; branch = 4'b1111; imm = 12'h020;
         flag_we = (k == 1); alu_flags = 3'b010;
         tick();
         chk("retw_busy", busy, 1'b1);
         chk("retw_pc", pc, 16'h0200);
      end
      idle_in();
      chk("retw_flags", flags, 3'b010);
      stall = 1; ret_vld = 1; ret_addr = 16'h0123;
      tick(); idle_in();
      chk("retv_pc", pc, 16'h0123);
      chk("retv_redirect", redirect, 1'b1);
      chk("retv_busy", busy, 1'b0);
      tick();
      chk("retv_after_pc", pc, 16'h0124);
      chk("retv_after_redirect", redirect, 1'b0);

      // CALL beats UNCOND branch: call 0x125+0x110=0x0235 (branch would give 0x0035)
      call = 1; branch = 4'b1111; imm = 12'h110;
      tick(); idle_in();
      chk("prio_pc", pc, 16'h0235);
`else
      // RAS: five nested CALLs of +0x10 from 0
      for (int k = 0; k < 5; k++) begin
         call = 1; imm = 12'h010;
         tick();
      end
      idle_in();
      chk("ras_calls_pc", pc, 16'h0055);
      ret = 1;
      tick(); chk("ras_ret1", pc, 16'h0045); chk("ras_ret1_redirect", redirect, 1'b1);
      tick(); chk("ras_ret2", pc, 16'h0034);
      tick(); chk("ras_ret3", pc, 16'h0023);
      tick(); chk("ras_ret4", pc, 16'h0012);
      tick(); idle_in();
      chk("ras_ret5_pc", pc, 16'h0012);
      chk("ras_ret5_busy", busy, 1'b1);
      ret_vld = 1; ret_addr = 16'h0235;
      tick(); idle_in();
      chk("ras_retv_pc", pc, 16'h0235);
`endif

      // HALT freezes pc and flags for 10 cycles
      hlt = 1;
      tick(); idle_in();
      chk("hlt_halted", halted, 1'b1);
      chk("hlt_pc", pc, 16'h0235);
      for (int k = 0; k < 10; k++) begin
         call = k[0]; branch = 4'b1111; ret = 1; flag_we = 1; alu_flags = 3'b111;
         ret_vld = 1; ret_addr = 16'h0777;
         tick();
         chk("halt_pc", pc, 16'h0235);
         chk("halt_halted", halted, 1'b1);
      end
      idle_in();
      chk("halt_flags_hold", flags == 3'b111, 1'b0);
      rst = 1; tick(); rst = 0;
      chk("unhalt_pc", pc, 16'h0000);
      chk("unhalt_halted", halted, 1'b0);
      chk("unhalt_flags", flags, 3'b000);
      tick();
      chk("unhalt_run_pc", pc, 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
